img_rsz_blk_avg: RTL and testbench
==================================

IMG_RSZ_BLK_AVG -- requirements
Module: img_rsz_blk_avg

Interface
REQ-001 SHALL take parameters from ImgRszPkg: PXL_PRIM_COLOR_W (8) bits per colour; PXL_PRIM_COLOR_NUM (3) colours per pixel; RSZ_IMG_WIDTH_SIZE (32) output columns; RSZ_IMG_HEIGHT_SIZE (32) output rows; BLK_WIDTH_MAX_SZ_W (6) and BLK_HEIGHT_MAX_SZ_W (6) block-size widths.
REQ-002 Clk  in  1  single clock; all logic on posedge Clk.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 PxlData_d1  in  FcRszPxlData_t  captured pixel, one colour per element.
REQ-005 PxlX_d1 / PxlY_d1  in  IMG_WIDTH_IDX_W / IMG_HEIGHT_IDX_W  pixel coordinates.
REQ-006 PxlVld_d1 in 1 / PxlRdy_d1 out 1  input valid/ready handshake.
REQ-007 ProcImgWidth / ProcImgHeight  in  IMG_*_IDX_W  dimensions of the current image.
REQ-008 BlkSzHor / BlkSzVer  in  BLK_*_MAX_SZ_W  block size in source pixels, stable for the whole image.
REQ-009 RszPxlData  out  FcRszPxlData_t  averaged output pixel.
REQ-010 RszPxlVld out 1 / RszPxlRdy in 1  output valid/ready handshake.
REQ-011 FwdRszEn  out  1  equals RszPxlVld & RszPxlRdy; feeds the capturer's serial forward counter.

Function
REQ-012 Accept a pixel when PxlVld_d1 & PxlRdy_d1; PxlRdy_d1 SHALL be 1 only in state ACC.
REQ-013 Keep one accumulator row of RSZ_IMG_WIDTH_SIZE entries; each entry holds one sum per colour, SUM_W = PXL_PRIM_COLOR_W+BLK_WIDTH_MAX_SZ_W+BLK_HEIGHT_MAX_SZ_W bits, plus a pixel count, CNT_W = BLK_WIDTH_MAX_SZ_W+BLK_HEIGHT_MAX_SZ_W bits; no overflow is possible.
REQ-014 Column index: HorInBlk counts 0..BlkSzHor-1 and ColIdx increments when HorInBlk wraps; both clear on an accepted pixel with PxlX_d1 == ProcImgWidth-1.
REQ-015 Accepted pixel adds each colour to Acc[ColIdx] and increments Cnt[ColIdx] in the same cycle; the sum is visible on the next cycle.
REQ-016 Row counter RowInBlk advances at each row end; a block-row end is a row end with RowInBlk == BlkSzVer-1 or PxlY_d1 == ProcImgHeight-1.
REQ-017 States: ACC -> DIV on a block-row end (after the accumulate); DIV -> OUT after exactly SUM_W cycles; OUT -> DIV on FwdRszEn while OutIdx < RSZ_IMG_WIDTH_SIZE-1; OUT -> ACC on FwdRszEn at the last OutIdx.
REQ-018 DIV SHALL compute Acc[OutIdx]/Cnt[OutIdx] per colour with the img_rsz_div sub-module, one instance per colour, all colours in parallel; the quotient is clamped to 2^PXL_PRIM_COLOR_W-1.
REQ-019 An entry with Cnt == 0 (image narrower than the output grid) SHALL output 0 without entering divide-by-zero.
REQ-020 RszPxlData and RszPxlVld SHALL stay stable in OUT until RszPxlRdy; on FwdRszEn, Acc[OutIdx] and Cnt[OutIdx] clear to 0 and OutIdx increments, wrapping to 0 on the transition to ACC.
REQ-021 Every block-row end, including a short last one, emits exactly RSZ_IMG_WIDTH_SIZE outputs.
REQ-022 RowInBlk SHALL clear when a block-row end is reached and after the last image row.

Reset
REQ-023 On Reset, including mid-image or mid-divide: state = ACC; all Acc, Cnt, HorInBlk, ColIdx, RowInBlk and OutIdx = 0; RszPxlVld = 0; RszPxlData = 0; FwdRszEn = 0; PxlRdy_d1 = 1 from the first cycle after Reset is released.

Configuration
REQ-024 With IMG_RSZ_ROUND_EN defined, the dividend SHALL be Acc + (Cnt>>1) (round half up); without it the quotient is truncated; latency is the same in both cases.

Structure
REQ-025 SUM_W, CNT_W, the state enum RszAvgState_t (ACC, DIV, OUT) and FcRszPxlData_t SHALL live in ImgRszPkg.
REQ-026 A single sub-module img_rsz_div (restoring divider, SUM_W/CNT_W bits, start/done, one bit per cycle) SHALL implement the divide.

Verification
REQ-027 Image 64x64, BlkSz 2x2, all pixels {10,20,30} -> 1024 outputs, each {10,20,30}; block-row outputs start SUM_W+1 cycles after the block-row end.
REQ-028 One 2x2 block with values 1,2,2,2 -> output 1 without IMG_RSZ_ROUND_EN, 2 with it.
REQ-029 Image 40x40, BlkSz 2x2 -> columns 20..31 output 0; 20 block rows emitted.
REQ-030 Image 63 rows, BlkSz 2 -> the last block row uses 1 row and is divided by count 2 per column.
REQ-031 RszPxlRdy held low 50 cycles in OUT -> RszPxlData stable, PxlRdy_d1 = 0, no accumulator changes.
REQ-032 Reset asserted during DIV -> next cycle state ACC, RszPxlVld = 0, a following 2x2 image averages correctly.

Source files
------------

// File: rtl/img_rsz_blk_avg_pkg.sv
// ImgRszPkg: shared sizes, pixel type and FSM states for the block-average resizer
package ImgRszPkg;
  localparam int PXL_PRIM_COLOR_W = 8;
  localparam int PXL_PRIM_COLOR_NUM = 3;
  localparam int RSZ_IMG_WIDTH_SIZE = 32;
  localparam int RSZ_IMG_HEIGHT_SIZE = 32;
  localparam int BLK_WIDTH_MAX_SZ_W = 6;
  localparam int BLK_HEIGHT_MAX_SZ_W = 6;
  // Largest source image is the output grid times the largest block
  localparam int IMG_WIDTH_IDX_W = 11;
  localparam int IMG_HEIGHT_IDX_W = 11;
  localparam int SUM_W = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;
  localparam int CNT_W = BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;
  localparam int COL_IDX_W = $clog2(RSZ_IMG_WIDTH_SIZE);
  localparam int DIV_CNT_W = $clog2(SUM_W);
  typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;
  typedef enum logic [1:0] {ACC, DIV, OUT} RszAvgState_t;
endpackage

// File: rtl/img_rsz_blk_avg_div.sv
// img_rsz_div: restoring divider, one quotient bit per cycle; Done marks the cycle of the final step
module img_rsz_div
  import ImgRszPkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SUM_W-1:0] Dividend,
  input  logic [CNT_W-1:0] Divisor,
  output logic             Done,
  output logic [SUM_W-1:0] Quotient
);
  logic                 busy;
  logic [DIV_CNT_W-1:0] stepCnt;
  logic [CNT_W:0]       rem, remIn, remNext;
  logic [SUM_W-1:0]     quoIn, quoNext;
  logic [CNT_W+1:0]     trial;
  // The start cycle already performs the first step so the whole divide takes SUM_W cycles
  always_comb begin
    remIn = Start ? '0 : rem;
    quoIn = Start ? Dividend : Quotient;
    trial = {remIn, quoIn[SUM_W-1]} - {2'b00, Divisor};
    remNext = trial[CNT_W+1] ? {remIn[CNT_W-1:0], quoIn[SUM_W-1]} : trial[CNT_W:0];
    quoNext = {quoIn[SUM_W-2:0], ~trial[CNT_W+1]};
  end
  assign Done = busy && stepCnt == DIV_CNT_W'(SUM_W - 1);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy <= 1'b0;
      stepCnt <= '0;
      rem <= '0;
      Quotient <= '0;
    end else if (Start || busy) begin
      busy <= Start || !Done;
      stepCnt <= Start ? DIV_CNT_W'(1) : stepCnt + 1'b1;
      rem <= remNext;
      Quotient <= quoNext;
    end
  end
endmodule

// File: rtl/img_rsz_blk_avg.sv
// img_rsz_blk_avg: block-average downscaler, one accumulator row divided out per block row
// Define IMG_RSZ_ROUND_EN for round-half-up averages instead of truncation.
module img_rsz_blk_avg
  import ImgRszPkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset,
  input  FcRszPxlData_t                  PxlData_d1,
  input  logic [IMG_WIDTH_IDX_W-1:0]     PxlX_d1,
  input  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY_d1,
  input  logic                           PxlVld_d1,
  output logic                           PxlRdy_d1,
  input  logic [IMG_WIDTH_IDX_W-1:0]     ProcImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]    ProcImgHeight,
  input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
  input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
  output FcRszPxlData_t                  RszPxlData,
  output logic                           RszPxlVld,
  input  logic                           RszPxlRdy,
  output logic                           FwdRszEn
);
  RszAvgState_t                                  State, StateNext;
  logic [SUM_W-1:0]                              Acc [RSZ_IMG_WIDTH_SIZE][PXL_PRIM_COLOR_NUM];
  logic [CNT_W-1:0]                              Cnt [RSZ_IMG_WIDTH_SIZE];
  logic [BLK_WIDTH_MAX_SZ_W-1:0]                 HorInBlk;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0]                RowInBlk;
  logic [COL_IDX_W-1:0]                          ColIdx, OutIdx;
  logic                                          PxlAcc, HorEnd, RowEnd, BlkRowEnd, LastOut, DivStart;
  logic [CNT_W-1:0]                              Divisor;
  logic [PXL_PRIM_COLOR_NUM-1:0]                 DivDone;
  logic [PXL_PRIM_COLOR_NUM-1:0][SUM_W-1:0]      Quo;
  assign PxlRdy_d1 = State == ACC;
  assign RszPxlVld = State == OUT;
  assign FwdRszEn = RszPxlVld & RszPxlRdy;
  assign PxlAcc = PxlVld_d1 & PxlRdy_d1;
  assign HorEnd = HorInBlk == BlkSzHor - 1'b1;
  assign RowEnd = PxlAcc && PxlX_d1 == ProcImgWidth - 1'b1;
  assign BlkRowEnd = RowEnd && (RowInBlk == BlkSzVer - 1'b1 || PxlY_d1 == ProcImgHeight - 1'b1);
  assign LastOut = OutIdx == COL_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
  // Empty columns divide 0 by 1, giving 0 with the normal latency
  assign Divisor = Cnt[OutIdx] == '0 ? CNT_W'(1) : Cnt[OutIdx];
  always_comb begin
    StateNext = State;
    if (State == ACC && BlkRowEnd) StateNext = DIV;
    if (State == DIV && &DivDone) StateNext = OUT;
    if (State == OUT && FwdRszEn) StateNext = LastOut ? ACC : DIV;
  end
  always_ff @(posedge Clk) begin
    if (Reset) State <= ACC;
    else State <= StateNext;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HorInBlk <= '0;
      ColIdx <= '0;
      RowInBlk <= '0;
      OutIdx <= '0;
      DivStart <= 1'b0;
      for (int i = 0; i < RSZ_IMG_WIDTH_SIZE; i++) begin
        Cnt[i] <= '0;
        for (int j = 0; j < PXL_PRIM_COLOR_NUM; j++) Acc[i][j] <= '0;
      end
    end else begin
      DivStart <= StateNext == DIV && State != DIV;
      if (PxlAcc) begin
        HorInBlk <= RowEnd || HorEnd ? '0 : HorInBlk + 1'b1;
        ColIdx <= RowEnd ? '0 : ColIdx + COL_IDX_W'(HorEnd);
        Cnt[ColIdx] <= Cnt[ColIdx] + 1'b1;
        for (int j = 0; j < PXL_PRIM_COLOR_NUM; j++) Acc[ColIdx][j] <= Acc[ColIdx][j] + SUM_W'(PxlData_d1[j]);
      end
      if (RowEnd) RowInBlk <= BlkRowEnd ? '0 : RowInBlk + 1'b1;
      if (FwdRszEn) begin
        OutIdx <= LastOut ? '0 : OutIdx + 1'b1;
        Cnt[OutIdx] <= '0;
        for (int j = 0; j < PXL_PRIM_COLOR_NUM; j++) Acc[OutIdx][j] <= '0;
      end
    end
  end
  for (genvar c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin : gDiv
    logic [SUM_W-1:0] dividend;
`ifdef IMG_RSZ_ROUND_EN
    assign dividend = Acc[OutIdx][c] + SUM_W'(Cnt[OutIdx] >> 1);
`else
    assign dividend = Acc[OutIdx][c];
`endif
    img_rsz_div uDiv (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (DivStart),
      .Dividend (dividend),
      .Divisor  (Divisor),
      .Done     (DivDone[c]),
      .Quotient (Quo[c])
    );
    assign RszPxlData[c] = State != OUT ? '0 :
                           |Quo[c][SUM_W-1:PXL_PRIM_COLOR_W] ? '1 : Quo[c][PXL_PRIM_COLOR_W-1:0];
  end
endmodule

// File: tb/tb_img_rsz_blk_avg.sv
// tb_img_rsz_blk_avg: directed-image bench for img_rsz_blk_avg with hand-computed block averages
module tb_img_rsz_blk_avg;
  import ImgRszPkg::*;
`ifdef IMG_RSZ_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  logic                           Clk = 1'b0, Reset = 1'b1;
  FcRszPxlData_t                  PxlData_d1 = '0, RszPxlData;
  logic [IMG_WIDTH_IDX_W-1:0]     PxlX_d1 = '0, ProcImgWidth = '0;
  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY_d1 = '0, ProcImgHeight = '0;
  logic                           PxlVld_d1 = 1'b0, PxlRdy_d1, RszPxlVld, RszPxlRdy = 1'b1, FwdRszEn;
  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor = '0;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer = '0;
  int                             nCmp = 0, nErr = 0, cyc = 0;
  FcRszPxlData_t                  outQ[$];
  int                             outCyc[$], endCycQ[$];

  img_rsz_blk_avg dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PxlData_d1    (PxlData_d1),
    .PxlX_d1       (PxlX_d1),
    .PxlY_d1       (PxlY_d1),
    .PxlVld_d1     (PxlVld_d1),
    .PxlRdy_d1     (PxlRdy_d1),
    .ProcImgWidth  (ProcImgWidth),
    .ProcImgHeight (ProcImgHeight),
    .BlkSzHor      (BlkSzHor),
    .BlkSzVer      (BlkSzVer),
    .RszPxlData    (RszPxlData),
    .RszPxlVld     (RszPxlVld),
    .RszPxlRdy     (RszPxlRdy),
    .FwdRszEn      (FwdRszEn)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  // Inputs only change on the falling edge, so this sample matches what the next rising edge sees
  always begin
    @(negedge Clk);
    #1;
    if (RszPxlVld && RszPxlRdy) begin
      outQ.push_back(RszPxlData);
      outCyc.push_back(cyc);
    end
  end

  task automatic checkVal(input string tag, input longint got, input longint exp);
    nCmp++;
    if (got != exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode 3 block: colour0 1,2,2,2; colour1 10,11,11,11; colour2 250,251,251,255
  function automatic FcRszPxlData_t pxlVal(input int mode, input int x, input int y);
    case (mode)
      0: return {8'd30, 8'd20, 8'd10};
      1: return {8'd255, 8'd100, 8'd5};
      2: return {8'd200, (x % 2 == 1 ? 8'd9 : 8'd6), (y == 62 ? 8'd100 : 8'd0)};
      3: return (x == 0 && y == 0) ? {8'd250, 8'd10, 8'd1} :
                (x == 1 && y == 1) ? {8'd255, 8'd11, 8'd2} : {8'd251, 8'd11, 8'd2};
      default: return {8'd60, 8'd50, 8'd40};
    endcase
  endfunction

  function automatic FcRszPxlData_t expVal(input int mode, input int r, input int k);
    case (mode)
      0: return {8'd30, 8'd20, 8'd10};
      1: return k < 20 ? {8'd255, 8'd100, 8'd5} : '0;
      2: return {8'd200, (RND ? 8'd8 : 8'd7), (r == 31 ? 8'd100 : 8'd0)};
      3: return k == 0 ? {(RND ? 8'd252 : 8'd251), (RND ? 8'd11 : 8'd10), (RND ? 8'd2 : 8'd1)} : '0;
      default: return k == 0 ? {8'd60, 8'd50, 8'd40} : '0;
    endcase
  endfunction

  task automatic sendPxl(input int x, input int y, input FcRszPxlData_t d, output int accCyc);
    int guard = 0;
    PxlX_d1 = IMG_WIDTH_IDX_W'(x);
    PxlY_d1 = IMG_HEIGHT_IDX_W'(y);
    PxlData_d1 = d;
    PxlVld_d1 = 1'b1;
    while (!PxlRdy_d1 && guard < 3000) begin
      @(negedge Clk);
      guard++;
    end
    if (guard == 3000) begin
      checkVal("rdy_timeout", guard, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $fatal(1, "input handshake stalled");
    end
    @(negedge Clk);
    accCyc = cyc;
    PxlVld_d1 = 1'b0;
  endtask

  task automatic sendImage(input int mode, input int w, input int h, input int bh, input int bv);
    int accCyc;
    ProcImgWidth = IMG_WIDTH_IDX_W'(w);
    ProcImgHeight = IMG_HEIGHT_IDX_W'(h);
    BlkSzHor = BLK_WIDTH_MAX_SZ_W'(bh);
    BlkSzVer = BLK_HEIGHT_MAX_SZ_W'(bv);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        sendPxl(x, y, pxlVal(mode, x, y), accCyc);
        if (x == w - 1 && (y % bv == bv - 1 || y == h - 1)) endCycQ.push_back(accCyc);
      end
  endtask

  task automatic waitOuts(input int n);
    int guard = 0;
    while (outQ.size() < n && guard < 5000) begin
      @(negedge Clk);
      guard++;
    end
    repeat (45) @(negedge Clk);
    checkVal("out_count", outQ.size(), n);
  endtask

  task automatic checkOuts(input int mode, input int nRows, input bit lat);
    for (int i = 0; i < outQ.size() && i < nRows * RSZ_IMG_WIDTH_SIZE; i++)
      checkVal($sformatf("m%0d_r%0d_c%0d", mode, i / RSZ_IMG_WIDTH_SIZE, i % RSZ_IMG_WIDTH_SIZE),
               outQ[i], expVal(mode, i / RSZ_IMG_WIDTH_SIZE, i % RSZ_IMG_WIDTH_SIZE));
    if (lat)
      for (int r = 0; r < nRows && r < endCycQ.size() && r * RSZ_IMG_WIDTH_SIZE < outQ.size(); r++)
        checkVal($sformatf("m%0d_r%0d_latency", mode, r), outCyc[r * RSZ_IMG_WIDTH_SIZE] - endCycQ[r], SUM_W);
    outQ.delete();
    outCyc.delete();
    endCycQ.delete();
  endtask

  initial begin
    FcRszPxlData_t hold;
    int stableBad = 0, rdyBad = 0, fwdBad = 0, guard = 0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkVal("rst_rdy", PxlRdy_d1, 1);
    checkVal("rst_vld", RszPxlVld, 0);
    checkVal("rst_data", RszPxlData, 0);
    checkVal("rst_fwd", FwdRszEn, 0);
    // Single 2x2 block: truncated vs rounded average
    sendImage(3, 2, 2, 2, 2);
    waitOuts(RSZ_IMG_WIDTH_SIZE);
    checkOuts(3, 1, 1'b1);
    // Output back-pressure: data held, input stalled, offered pixel ignored
    RszPxlRdy = 1'b0;
    sendImage(3, 2, 2, 2, 2);
    while (!RszPxlVld && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    checkVal("hold_vld", RszPxlVld, 1);
    hold = RszPxlData;
    PxlX_d1 = '0;
    PxlY_d1 = '0;
    PxlData_d1 = {8'd99, 8'd99, 8'd99};
    PxlVld_d1 = 1'b1;
    repeat (50) begin
      @(negedge Clk);
      stableBad += int'(RszPxlData != hold || !RszPxlVld);
      rdyBad += int'(PxlRdy_d1);
      fwdBad += int'(FwdRszEn);
    end
    checkVal("hold_data", hold, expVal(3, 0, 0));
    checkVal("hold_stable", stableBad, 0);
    checkVal("hold_pxl_rdy", rdyBad, 0);
    checkVal("hold_fwd_en", fwdBad, 0);
    PxlVld_d1 = 1'b0;
    RszPxlRdy = 1'b1;
    waitOuts(RSZ_IMG_WIDTH_SIZE);
    checkOuts(3, 1, 1'b0);
    // Reset in the middle of a divide, then a fresh image must not see old sums
    sendImage(3, 2, 2, 2, 2);
    repeat (5) @(negedge Clk);
    checkVal("div_pxl_rdy", PxlRdy_d1, 0);
    checkVal("div_vld", RszPxlVld, 0);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checkVal("mid_rst_rdy", PxlRdy_d1, 1);
    checkVal("mid_rst_vld", RszPxlVld, 0);
    checkVal("mid_rst_data", RszPxlData, 0);
    outQ.delete();
    outCyc.delete();
    endCycQ.delete();
    sendImage(4, 2, 2, 2, 2);
    waitOuts(RSZ_IMG_WIDTH_SIZE);
    checkOuts(4, 1, 1'b1);
    // Full 64x64 uniform image
    sendImage(0, 64, 64, 2, 2);
    waitOuts(32 * RSZ_IMG_WIDTH_SIZE);
    checkOuts(0, 32, 1'b1);
    // Narrow 40x40 image leaves columns 20..31 empty
    sendImage(1, 40, 40, 2, 2);
    waitOuts(20 * RSZ_IMG_WIDTH_SIZE);
    checkOuts(1, 20, 1'b1);
    // 63 rows: short last block row divides by 2
    sendImage(2, 64, 63, 2, 2);
    waitOuts(32 * RSZ_IMG_WIDTH_SIZE);
    checkOuts(2, 32, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
